router_pkt_rx: RTL and testbench
================================

ROUTER_PKT_RX -- requirements
Module: router_pkt_rx

Interface
REQ-001 Parameter DEPTH, 16, payload FIFO depth in bytes (power of two, >=4).
REQ-002 Parameter TIMEOUT, 32, idle cycles allowed inside a packet before abort.
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 reset  input  1  asynchronous, active-low reset (asserts immediately when low, releases synchronously to clk).
REQ-005 rx_data  input  8  byte from router DUT output (dut_outp).
REQ-006 rx_valid  input  1  rx_data valid this cycle (outp_valid); no backpressure exists upstream.
REQ-007 pld_data  output  8  payload byte at FIFO head.
REQ-008 pld_last  output  1  head byte is final payload byte of its packet.
REQ-009 pld_valid  output  1  FIFO not empty.
REQ-010 pld_ready  input  1  consumer accepts head byte when pld_valid and pld_ready are both high.
REQ-011 pkt_done  output  1  one-cycle pulse: packet finished or aborted.
REQ-012 pkt_da / pkt_sa / pkt_len  output  8 each  header fields of last finished packet, held until next pkt_done.
REQ-013 pkt_err  output  4  status of last packet: [0] checksum, [1] zero length, [2] FIFO overflow, [3] timeout.
REQ-014 pkt_count / err_count  output  16 each  packets finished / packets with pkt_err != 0; saturate at 16'hFFFF.

Function
REQ-015 Frame: DA, SA, LEN, LEN payload bytes, checksum; checksum = XOR of DA, SA, LEN and all payload bytes.
REQ-016 FSM states S_DA, S_SA, S_LEN, S_PLD, S_CSUM; advance only on cycles with rx_valid high.
REQ-017 S_DA->S_SA->S_LEN; S_LEN->S_PLD if LEN!=0, else S_CSUM with err[1] set; S_PLD->S_CSUM after LEN-th payload byte; S_CSUM->S_DA.
REQ-018 Each payload byte is pushed into the FIFO in the same cycle it is sampled; pld_last set on the LEN-th byte.
REQ-019 Push latency: byte sampled at edge N is visible on pld_data/pld_valid after edge N.
REQ-020 Push is accepted when FIFO count < DEPTH, or when count == DEPTH and a pop occurs in the same cycle; otherwise the byte is dropped and err[2] set; FSM still advances.
REQ-021 Simultaneous push and pop at any count leaves count unchanged; pointers wrap modulo DEPTH.
REQ-022 Checksum mismatch in S_CSUM sets err[0]; payload already in FIFO is not retracted.
REQ-023 pkt_done pulses the cycle after the checksum byte is sampled; pkt_da/sa/len/err update in that same cycle.
REQ-024 In states other than S_DA, TIMEOUT consecutive cycles with rx_valid low abort the packet: err[3] set, pkt_done pulse, return to S_DA; the idle counter clears on any rx_valid.
REQ-025 Aborted packet pushes no further bytes; bytes already pushed remain, without pld_last.
REQ-026 Counters increment on pkt_done; err_count only if pkt_err != 0; both hold at 16'hFFFF.

Reset
REQ-027 While reset is low: FSM = S_DA, FIFO empty, pld_valid=0, pld_last=0, pld_data=0, pkt_done=0, pkt_da/sa/len=0, pkt_err=0, counters=0, idle counter=0.
REQ-028 Reset mid-packet discards the partial packet and all FIFO contents; no pkt_done is generated.

Structure
REQ-029 Package router_pkg holds the state enum, pkt_err bit index constants, and DEPTH/TIMEOUT defaults.
REQ-030 FIFO is sub-module router_byte_fifo (9-bit entries: data + last), instantiated once.

Verification
REQ-031 Frame 11 22 03 AA BB CC ED, pld_ready=1 -> pld_data AA,BB,CC with pld_last on CC; pkt_done, pkt_err=0, pkt_count=1.
REQ-032 Same frame with checksum 00 -> payload delivered, pkt_err=4'b0001, err_count=1.
REQ-033 Frame 11 22 00 33 -> no FIFO push, pkt_err=4'b0010.
REQ-034 pld_ready=0, LEN=20 valid frame -> 16 bytes stored, 4 dropped, pkt_err=4'b0100; then a pop and push in the same cycle at count 16 -> push accepted, count stays 16.
REQ-035 Send 11 22 05 AA then rx_valid low 32 cycles -> pkt_done with pkt_err=4'b1000, FSM back to S_DA; next valid frame decodes cleanly.
REQ-036 Pull reset low mid-payload -> all outputs at reset values immediately; following frame decodes with pkt_count=1.

Source files
------------

// File: rtl/router_pkg.sv
// Shared types and constants for the router packet receiver.
package router_pkg;

    localparam int unsigned DEPTH_DEFAULT   = 16;
    localparam int unsigned TIMEOUT_DEFAULT = 32;

    // Bit positions inside pkt_err
    localparam int unsigned ERR_CSUM = 0;
    localparam int unsigned ERR_ZLEN = 1;
    localparam int unsigned ERR_OVF  = 2;
    localparam int unsigned ERR_TMO  = 3;

    typedef enum logic [2:0] {
        S_DA,
        S_SA,
        S_LEN,
        S_PLD,
        S_CSUM
    } rx_state_e;

    // Increment that sticks at all-ones
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/router_pkt_rx_if.sv
// Byte stream in, payload stream out, plus per-packet status.
interface router_pkt_rx_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  pld_data;
    logic        pld_last;
    logic        pld_valid;
    logic        pld_ready;
    logic        pkt_done;
    logic [7:0]  pkt_da;
    logic [7:0]  pkt_sa;
    logic [7:0]  pkt_len;
    logic [3:0]  pkt_err;
    logic [15:0] pkt_count;
    logic [15:0] err_count;

    // Environment side: drives the byte stream and the payload consumer ready
    modport master (
        output rx_data, rx_valid, pld_ready,
        input  pld_data, pld_last, pld_valid, pkt_done, pkt_da, pkt_sa, pkt_len,
        input  pkt_err, pkt_count, err_count
    );

    // Receiver side
    modport slave (
        input  rx_data, rx_valid, pld_ready,
        output pld_data, pld_last, pld_valid, pkt_done, pkt_da, pkt_sa, pkt_len,
        output pkt_err, pkt_count, err_count
    );
endinterface

// File: rtl/router_byte_fifo.sv
// Payload FIFO: 9-bit entries {last, data}, head shown combinationally.
module router_byte_fifo #(
    parameter int unsigned DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic [8:0] push_entry,
    output logic       push_ok,
    input  logic       pop,
    output logic [8:0] head,
    output logic       not_empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [8:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    // A full FIFO still takes a byte when the head leaves in the same cycle
    always_comb begin
        not_empty = (count_q != '0);
        do_pop    = pop && not_empty;
        push_ok   = (count_q < FULL_COUNT) || do_pop;
        do_push   = push && push_ok;
        head      = not_empty ? mem_q[rd_ptr_q] : '0;
    end

    // Storage write, no reset needed since empty masks the head
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    // Pointers wrap naturally as DEPTH is a power of two
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/router_pkt_rx.sv
// Frame decoder: DA, SA, LEN, payload, XOR checksum; payload goes to a FIFO.
module router_pkt_rx
    import router_pkg::*;
#(
    parameter int unsigned DEPTH   = DEPTH_DEFAULT,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input logic             clk,
    input logic             reset,
    router_pkt_rx_if.slave  bus
);

    localparam int unsigned IW = $clog2(TIMEOUT + 1);
    localparam logic [IW-1:0] IDLE_LIMIT = IW'(TIMEOUT - 1);

    rx_state_e     state_q;
    logic [7:0]    da_q;
    logic [7:0]    sa_q;
    logic [7:0]    len_q;
    logic [7:0]    rem_q;
    logic [7:0]    csum_q;
    logic [3:0]    err_acc_q;
    logic [IW-1:0] idle_q;

    logic          pkt_done_q;
    logic [7:0]    pkt_da_q;
    logic [7:0]    pkt_sa_q;
    logic [7:0]    pkt_len_q;
    logic [3:0]    pkt_err_q;
    logic [15:0]   pkt_count_q;
    logic [15:0]   err_count_q;

    logic          push;
    logic [8:0]    push_entry;
    logic          push_ok;
    logic          pop;
    logic [8:0]    head;
    logic          fifo_valid;
    logic          timeout_hit;
    logic          done_now;
    logic [3:0]    done_err;
    logic [3:0]    final_err;
    logic [3:0]    abort_err;

    // Datapath decode for the current cycle
    always_comb begin
        push        = (state_q == S_PLD) && bus.rx_valid;
        push_entry  = {rem_q == 8'd1, bus.rx_data};
        pop         = fifo_valid && bus.pld_ready;
        timeout_hit = (state_q != S_DA) && !bus.rx_valid && (idle_q == IDLE_LIMIT);

        final_err           = err_acc_q;
        final_err[ERR_CSUM] = (bus.rx_data != csum_q);
        abort_err           = err_acc_q;
        abort_err[ERR_TMO]  = 1'b1;

        done_now = timeout_hit || (bus.rx_valid && (state_q == S_CSUM));
        done_err = timeout_hit ? abort_err : final_err;
    end

    router_byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_entry (push_entry),
        .push_ok    (push_ok),
        .pop        (pop),
        .head       (head),
        .not_empty  (fifo_valid)
    );

    // Frame FSM, idle watchdog and registered status outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_DA;
            da_q        <= '0;
            sa_q        <= '0;
            len_q       <= '0;
            rem_q       <= '0;
            csum_q      <= '0;
            err_acc_q   <= '0;
            idle_q      <= '0;
            pkt_done_q  <= 1'b0;
            pkt_da_q    <= '0;
            pkt_sa_q    <= '0;
            pkt_len_q   <= '0;
            pkt_err_q   <= '0;
            pkt_count_q <= '0;
            err_count_q <= '0;
        end else begin
            pkt_done_q <= 1'b0;

            if (bus.rx_valid || state_q == S_DA) begin
                idle_q <= '0;
            end else begin
                idle_q <= idle_q + 1'b1;
            end

            if (done_now) begin
                pkt_done_q  <= 1'b1;
                pkt_da_q    <= da_q;
                pkt_sa_q    <= sa_q;
                pkt_len_q   <= len_q;
                pkt_err_q   <= done_err;
                pkt_count_q <= sat_inc(pkt_count_q);
                if (done_err != 4'd0) begin
                    err_count_q <= sat_inc(err_count_q);
                end
            end

            if (timeout_hit) begin
                state_q <= S_DA;
                idle_q  <= '0;
            end else if (bus.rx_valid) begin
                unique case (state_q)
                    S_DA: begin
                        // Clear header so an early abort reports no stale fields
                        da_q      <= bus.rx_data;
                        sa_q      <= '0;
                        len_q     <= '0;
                        csum_q    <= bus.rx_data;
                        err_acc_q <= '0;
                        state_q   <= S_SA;
                    end
                    S_SA: begin
                        sa_q    <= bus.rx_data;
                        csum_q  <= csum_q ^ bus.rx_data;
                        state_q <= S_LEN;
                    end
                    S_LEN: begin
                        len_q  <= bus.rx_data;
                        rem_q  <= bus.rx_data;
                        csum_q <= csum_q ^ bus.rx_data;
                        if (bus.rx_data == 8'd0) begin
                            err_acc_q[ERR_ZLEN] <= 1'b1;
                            state_q             <= S_CSUM;
                        end else begin
                            state_q <= S_PLD;
                        end
                    end
                    S_PLD: begin
                        // Dropped bytes still count toward LEN
                        csum_q <= csum_q ^ bus.rx_data;
                        rem_q  <= rem_q - 8'd1;
                        if (!push_ok) begin
                            err_acc_q[ERR_OVF] <= 1'b1;
                        end
                        if (rem_q == 8'd1) begin
                            state_q <= S_CSUM;
                        end
                    end
                    S_CSUM: begin
                        state_q <= S_DA;
                    end
                    default: begin
                        state_q <= S_DA;
                    end
                endcase
            end
        end
    end

    // Drive interface outputs
    always_comb begin
        bus.pld_data  = head[7:0];
        bus.pld_last  = head[8];
        bus.pld_valid = fifo_valid;
        bus.pkt_done  = pkt_done_q;
        bus.pkt_da    = pkt_da_q;
        bus.pkt_sa    = pkt_sa_q;
        bus.pkt_len   = pkt_len_q;
        bus.pkt_err   = pkt_err_q;
        bus.pkt_count = pkt_count_q;
        bus.err_count = err_count_q;
    end

endmodule

// File: tb/tb_router_pkt_rx.sv
// Scoreboard bench for router_pkt_rx: stimulus pushes expectations, a monitor pops and compares.
module tb_router_pkt_rx;

    localparam int DEPTH   = 16;
    localparam int TIMEOUT = 32;

    typedef struct packed {
        logic [7:0]  da;
        logic [7:0]  sa;
        logic [7:0]  len;
        logic [3:0]  err;
        logic [15:0] pc;
        logic [15:0] ec;
        logic        hdr;
    } pkt_exp_t;

    logic clk;
    logic reset;
    router_pkt_rx_if bus ();

    router_pkt_rx #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [8:0] exp_pld[$];
    pkt_exp_t   exp_pkt[$];
    logic [7:0] pl_q[$];
    int         occ = 0;
    int         m_pkt = 0;
    int         m_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bus.rx_valid = 1'b0;
        repeat (gap) tick();
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        tick();
        bus.rx_valid = 1'b0;
    endtask

    task automatic expect_pkt(input logic [7:0] da, sa, len, input logic [3:0] err,
                              input logic hdr);
        pkt_exp_t e;
        if (m_pkt < 65535) m_pkt++;
        if (err != 4'd0 && m_err < 65535) m_err++;
        e.da = da; e.sa = sa; e.len = len; e.err = err;
        e.pc = 16'(m_pkt); e.ec = 16'(m_err); e.hdr = hdr;
        exp_pkt.push_back(e);
    endtask

    // Sends DA, SA, LEN=pl_q.size(), pl_q, checksum (xor cs_flip); builds expectations
    task automatic send_frame(input logic [7:0] da, sa, input logic [7:0] cs_flip,
                              input int max_gap);
        logic [7:0] len;
        logic [7:0] cs;
        logic [3:0] err;
        int n;
        n   = pl_q.size();
        len = 8'(n);
        cs  = da ^ sa ^ len;
        err = 4'd0;
        for (int i = 0; i < n; i++) cs ^= pl_q[i];
        if (n == 0) err[1] = 1'b1;
        if (cs_flip != 8'd0) err[0] = 1'b1;
        send_byte(da, $urandom_range(0, max_gap));
        send_byte(sa, $urandom_range(0, max_gap));
        send_byte(len, $urandom_range(0, max_gap));
        for (int i = 0; i < n; i++) begin
            if (bus.pld_ready) begin
                exp_pld.push_back({i == n - 1, pl_q[i]});
            end else if (occ < DEPTH) begin
                occ++;
                exp_pld.push_back({i == n - 1, pl_q[i]});
            end else begin
                err[2] = 1'b1;
            end
            send_byte(pl_q[i], $urandom_range(0, max_gap));
        end
        expect_pkt(da, sa, len, err, 1'b1);
        send_byte(cs ^ cs_flip, $urandom_range(0, max_gap));
    endtask

    task automatic wait_drain(input string name);
        int cyc;
        cyc = 0;
        while ((exp_pld.size() != 0 || exp_pkt.size() != 0) && cyc < 2000) begin
            tick();
            cyc++;
        end
        repeat (3) tick();
        check({name, "_pld_left"}, exp_pld.size(), 0);
        check({name, "_pkt_left"}, exp_pkt.size(), 0);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_pld_valid"}, bus.pld_valid, 0);
        check({name, "_pld_last"}, bus.pld_last, 0);
        check({name, "_pld_data"}, bus.pld_data, 0);
        check({name, "_pkt_done"}, bus.pkt_done, 0);
        check({name, "_pkt_hdr"}, {bus.pkt_da, bus.pkt_sa, bus.pkt_len}, 0);
        check({name, "_pkt_err"}, bus.pkt_err, 0);
        check({name, "_counts"}, {bus.pkt_count, bus.err_count}, 0);
    endtask

    // Monitor: compares every payload handshake and every pkt_done against the queues
    always @(negedge clk) begin
        if (reset) begin
            if (bus.pld_valid && bus.pld_ready) begin
                if (exp_pld.size() == 0) begin
                    check("pld_unexpected", {bus.pld_last, bus.pld_data}, 9'h1ff);
                end else begin
                    check("pld_byte", {bus.pld_last, bus.pld_data}, exp_pld.pop_front());
                end
            end
            if (bus.pkt_done) begin
                if (exp_pkt.size() == 0) begin
                    check("pkt_unexpected", bus.pkt_err, 4'hf);
                end else begin
                    pkt_exp_t e;
                    e = exp_pkt.pop_front();
                    if (e.hdr) begin
                        check("pkt_hdr", {bus.pkt_da, bus.pkt_sa, bus.pkt_len},
                              {e.da, e.sa, e.len});
                    end
                    check("pkt_err", bus.pkt_err, e.err);
                    check("pkt_count", bus.pkt_count, e.pc);
                    check("err_count", bus.err_count, e.ec);
                end
            end
        end
    end

    initial begin
        logic [7:0] cs;
        int cyc;
        reset         = 1'b0;
        bus.rx_data   = '0;
        bus.rx_valid  = 1'b0;
        bus.pld_ready = 1'b1;
        #3;
        check_reset_outputs("por");
        repeat (3) tick();
        reset = 1'b1;
        repeat (2) tick();

        // Clean frame 11 22 03 AA BB CC ED
        pl_q = '{8'hAA, 8'hBB, 8'hCC};
        send_frame(8'h11, 8'h22, 8'h00, 0);
        wait_drain("good");

        // Same frame, checksum ED xor ED = 00
        pl_q = '{8'hAA, 8'hBB, 8'hCC};
        send_frame(8'h11, 8'h22, 8'hED, 1);
        wait_drain("badcs");

        // Zero length 11 22 00 33
        pl_q = {};
        send_frame(8'h11, 8'h22, 8'h00, 0);
        wait_drain("zlen");

        // Overflow: consumer stalled, LEN=20
        bus.pld_ready = 1'b0;
        occ = 0;
        pl_q = {};
        for (int i = 0; i < 20; i++) pl_q.push_back(8'(i + 8'h40));
        send_frame(8'h5A, 8'hA5, 8'h00, 0);
        repeat (3) tick();
        check("ovf_pending", exp_pkt.size(), 0);

        // FIFO full: one payload byte arrives in the same cycle as a pop
        send_byte(8'h77, 0);
        send_byte(8'h88, 0);
        send_byte(8'h01, 0);
        exp_pld.push_back({1'b1, 8'h99});
        bus.pld_ready = 1'b1;
        send_byte(8'h99, 0);
        bus.pld_ready = 1'b0;
        cs = 8'h77 ^ 8'h88 ^ 8'h01 ^ 8'h99;
        expect_pkt(8'h77, 8'h88, 8'h01, 4'b0000, 1'b1);
        send_byte(cs, 0);
        repeat (3) tick();
        check("full_pld_valid", bus.pld_valid, 1);
        bus.pld_ready = 1'b1;
        occ = 0;
        wait_drain("ovf");

        // Timeout: 11 22 05 AA then silence
        exp_pld.push_back({1'b0, 8'hAA});
        expect_pkt(8'h11, 8'h22, 8'h05, 4'b1000, 1'b0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h05, 0);
        send_byte(8'hAA, 0);
        cyc = 0;
        while (!bus.pkt_done && cyc < 100) begin
            tick();
            cyc++;
        end
        check("timeout_cycles", cyc, TIMEOUT);
        wait_drain("tmo");
        pl_q = '{8'h01, 8'h02};
        send_frame(8'h33, 8'h44, 8'h00, 2);
        wait_drain("after_tmo");

        // Randomized frames with short bubbles
        for (int f = 0; f < 40; f++) begin
            int n;
            logic [7:0] flip;
            n = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 10);
            pl_q = {};
            for (int i = 0; i < n; i++) pl_q.push_back(8'($urandom_range(0, 255)));
            flip = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            send_frame(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), flip, 3);
            repeat ($urandom_range(0, 4)) tick();
        end
        wait_drain("random");

        // Reset mid-payload with bytes parked in the FIFO
        bus.pld_ready = 1'b0;
        send_byte(8'h10, 0);
        send_byte(8'h20, 0);
        send_byte(8'h05, 0);
        send_byte(8'hC1, 0);
        send_byte(8'hC2, 0);
        check("pre_reset_valid", bus.pld_valid, 1);
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        exp_pld.delete();
        occ   = 0;
        m_pkt = 0;
        m_err = 0;
        bus.pld_ready = 1'b1;
        repeat (3) tick();
        reset = 1'b1;
        repeat (2) tick();
        pl_q = '{8'hAA, 8'hBB, 8'hCC};
        send_frame(8'h11, 8'h22, 8'h00, 1);
        wait_drain("post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
